// File: rtl/oct_period_ctrl.sv
// Measures the ADC input period (hysteresis rising crossings) and drives the octave
// generator half-period, (P>>2)-1. Define OCT_CTRL_AVG_EN to average the last two periods.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  SEARCH    | no signal; waiting for a sample at or below TH_LOW
//  ARM       | low level seen; first rising crossing starts the count
//  MEAS_HIGH | counting; input above TH_HIGH, waiting for it to go low
//  MEAS_LOW  | counting; input low, next rising crossing completes P
module oct_period_ctrl #(
    parameter logic [11:0] TH_LOW     = 12'd1948,
    parameter logic [11:0] TH_HIGH    = 12'd2148,
    parameter logic [31:0] MIN_PERIOD = 32'd8,
    parameter logic [31:0] MAX_PERIOD = 32'd5000000
) (
    input  logic        CLK_in,
    input  logic        RST_in,
    input  logic [11:0] adc_data_in,
    input  logic        adc_valid_in,
    output logic [31:0] periodo_out,
    output logic        periodo_valid_out,
    output logic        locked_out
);

    typedef enum logic [1:0] {SEARCH, ARM, MEAS_HIGH, MEAS_LOW} state_t;

    state_t      state;
    logic [31:0] cnt;
    logic        is_low;
    logic        is_high;
    logic        meas;
    logic        timeout;
    logic [31:0] next_period;

    assign is_low  = adc_valid_in && (adc_data_in <= TH_LOW);
    assign is_high = adc_valid_in && (adc_data_in >= TH_HIGH);
    assign meas    = (state == MEAS_HIGH) || (state == MEAS_LOW);
    assign timeout = meas && (cnt == MAX_PERIOD);

`ifdef OCT_CTRL_AVG_EN
    // prev == 0 marks "no accepted period since SEARCH"; accepted P is always >= 8
    logic [31:0] prev;
    logic [32:0] sum;
    assign sum         = {1'b0, cnt} + {1'b0, prev};
    assign next_period = (prev == 32'd0) ? ((cnt >> 2) - 32'd1)
                                         : (32'(sum >> 3) - 32'd1);
`else
    assign next_period = (cnt >> 2) - 32'd1;
`endif

    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            state             <= SEARCH;
            cnt               <= 32'd0;
            periodo_out       <= 32'd0;
            periodo_valid_out <= 1'b0;
            locked_out        <= 1'b0;
`ifdef OCT_CTRL_AVG_EN
            prev              <= 32'd0;
`endif
        end else begin
            periodo_valid_out <= 1'b0;
            if (meas)
                cnt <= cnt + 32'd1;

            if (timeout) begin
                state             <= SEARCH;
                cnt               <= 32'd0;
                periodo_out       <= 32'd0;
                periodo_valid_out <= 1'b1;
                locked_out        <= 1'b0;
`ifdef OCT_CTRL_AVG_EN
                prev              <= 32'd0;
`endif
            end else begin
                case (state)
                    SEARCH: begin
                        if (is_low)
                            state <= ARM;
                    end
                    ARM: begin
                        if (is_high) begin
                            state <= MEAS_HIGH;
                            cnt   <= 32'd1;
                        end
                    end
                    MEAS_HIGH: begin
                        if (is_low)
                            state <= MEAS_LOW;
                    end
                    MEAS_LOW: begin
                        if (is_high) begin
                            // a glitch edge still becomes the new reference
                            state <= MEAS_HIGH;
                            cnt   <= 32'd1;
                            if (cnt >= MIN_PERIOD) begin
                                periodo_out       <= next_period;
                                periodo_valid_out <= 1'b1;
                                locked_out        <= 1'b1;
`ifdef OCT_CTRL_AVG_EN
                                prev              <= cnt;
`endif
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oct_period_ctrl.sv
// Directed bench for oct_period_ctrl; timeout shortened to 3000 clocks to keep runs short.
module tb_oct_period_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] adc_data = 12'd0;
    logic        adc_valid = 1'b0;
    logic [31:0] periodo;
    logic        periodo_valid;
    logic        locked;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pulse_ref;
    logic [31:0] exp_val;

    oct_period_ctrl #(
        .TH_LOW(12'd1948),
        .TH_HIGH(12'd2148),
        .MIN_PERIOD(32'd8),
        .MAX_PERIOD(32'd3000)
    ) dut (
        .CLK_in(clk),
        .RST_in(rst),
        .adc_data_in(adc_data),
        .adc_valid_in(adc_valid),
        .periodo_out(periodo),
        .periodo_valid_out(periodo_valid),
        .locked_out(locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && periodo_valid)
            pulse_cnt <= pulse_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic hold(input logic [11:0] v, input int n);
        adc_data  = v;
        adc_valid = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) begin @(posedge clk); #1; end
        check("reset_periodo", periodo, 32'd0);
        check("reset_valid", {31'd0, periodo_valid}, 32'd0);
        check("reset_locked", {31'd0, locked}, 32'd0);
        rst = 1'b0;

        // 1: square wave, period 1000
        hold(12'd0, 10);
        hold(12'd4095, 500);
        hold(12'd0, 500);
        check("t1_no_pulse_first_edge", pulse_cnt, 0);
        hold(12'd4095, 1);
        check("t1_periodo", periodo, 32'd249);
        check("t1_valid", {31'd0, periodo_valid}, 32'd1);
        check("t1_locked", {31'd0, locked}, 32'd1);
        hold(12'd4095, 1);
        check("t1_valid_one_cycle", {31'd0, periodo_valid}, 32'd0);
        check("t1_pulse_count", pulse_cnt, 1);
        hold(12'd4095, 498);

        // 2: periods 1002 then 1004
        hold(12'd0, 502);
        hold(12'd4095, 1);
        check("t2_p1002", periodo, 32'd249);
        hold(12'd4095, 501);
        hold(12'd0, 502);
        hold(12'd4095, 1);
`ifdef OCT_CTRL_AVG_EN
        exp_val = 32'd249;
`else
        exp_val = 32'd250;
`endif
        check("t2_p1004", periodo, exp_val);

        // 3: input parks mid-band until timeout
        pulse_ref = pulse_cnt + 1;
        hold(12'd2048, 2999);
        check("t3_pre_timeout_locked", {31'd0, locked}, 32'd1);
        hold(12'd2048, 1);
        check("t3_timeout_periodo", periodo, 32'd0);
        check("t3_timeout_locked", {31'd0, locked}, 32'd0);
        check("t3_timeout_valid", {31'd0, periodo_valid}, 32'd1);
        hold(12'd2048, 5);
        check("t3_single_pulse", pulse_cnt, pulse_ref + 1);

        // 4: oscillation inside hysteresis band
        pulse_ref = pulse_cnt;
        for (int i = 0; i < 200; i++)
            hold((i % 2 == 0) ? 12'd2000 : 12'd2100, 1);
        check("t4_no_pulses", pulse_cnt, pulse_ref);
        check("t4_periodo", periodo, 32'd0);

        // 5: spike pair 4 clk apart, then period 1000 from the second spike
        hold(12'd0, 10);
        hold(12'd4095, 2);
        hold(12'd0, 2);
        hold(12'd4095, 2);
        check("t5_spike_rejected", pulse_cnt, pulse_ref);
        hold(12'd4095, 498);
        hold(12'd0, 500);
        hold(12'd4095, 1);
        check("t5_periodo", periodo, 32'd249);
        check("t5_valid", {31'd0, periodo_valid}, 32'd1);

        // 6: reset mid MEAS_LOW, then re-lock
        hold(12'd4095, 499);
        hold(12'd0, 100);
        rst = 1'b1;
        hold(12'd4095, 1);
        check("t6_rst_periodo", periodo, 32'd0);
        check("t6_rst_locked", {31'd0, locked}, 32'd0);
        check("t6_rst_valid", {31'd0, periodo_valid}, 32'd0);
        rst = 1'b0;
        pulse_ref = pulse_cnt;
        hold(12'd4095, 600);
        hold(12'd0, 400);
        hold(12'd4095, 600);
        hold(12'd0, 400);
        check("t6_no_pulse_before_relock", pulse_cnt, pulse_ref);
        hold(12'd4095, 1);
        check("t6_relock_periodo", periodo, 32'd249);
        check("t6_relock_locked", {31'd0, locked}, 32'd1);

        // 7: period 1200 after 1000
        hold(12'd4095, 599);
        hold(12'd0, 600);
        hold(12'd4095, 1);
`ifdef OCT_CTRL_AVG_EN
        exp_val = 32'd274;
`else
        exp_val = 32'd299;
`endif
        check("t7_p1200", periodo, exp_val);

        // boundary: P = MIN_PERIOD accepted, P = 7 rejected
        hold(12'd4095, 3);
        hold(12'd0, 4);
        hold(12'd4095, 1);
`ifdef OCT_CTRL_AVG_EN
        exp_val = 32'd150;
`else
        exp_val = 32'd1;
`endif
        check("min_period_value", periodo, exp_val);
        check("min_period_valid", {31'd0, periodo_valid}, 32'd1);
        hold(12'd4095, 3);
        hold(12'd0, 3);
        hold(12'd4095, 1);
        check("below_min_no_valid", {31'd0, periodo_valid}, 32'd0);
        check("below_min_hold", periodo, exp_val);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
